mesm6_alu_ctl: RTL

Sequencing controller for the MESM-6 48-bit ALU. It accepts one operation at a time from the instruction decoder over a valid/ready handshake and latches the operands. It drives the ALU's `a`/`b`/`op` inputs, waits for `done`, and returns `result`/`y` over a second valid/ready handshake. Between operations it forces `ALU_NOP` for at least one clock edge, because the ALU's `done` flag is sticky and only `ALU_NOP` clears it. The block sits between the decoder and the ALU instance in the execution unit.

---
 rtl/mesm6_pkg.sv | 28 ++
 rtl/mesm6_alu_ctl_if.sv | 26 ++
 rtl/mesm6_alu.sv | 51 +++++
 rtl/mesm6_alu_ctl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mesm6_pkg.sv
// Shared MESM-6 definitions: ALU opcode encoding, ALU controller state and response types.
package mesm6_pkg;

    localparam int ALU_OP_WIDTH = 5;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_NOP              = 5'd0;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND              = 5'd1;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR               = 5'd2;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR              = 5'd3;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD_CARRY_AROUND = 5'd4;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FADD             = 5'd8;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FMUL             = 5'd9;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_FDIV             = 5'd10;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SHIFT            = 5'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } alu_ctl_state_t;

    typedef struct packed {
        logic [47:0] result;
        logic [47:0] y;
        logic        err;
    } alu_rsp_t;

endpackage

// File: rtl/mesm6_alu_ctl_if.sv
// Decoder-side request/response handshake of the MESM-6 ALU controller.
interface mesm6_alu_ctl_if;
    import mesm6_pkg::*;

    logic                    req_valid;
    logic                    req_ready;
    logic [ALU_OP_WIDTH-1:0] req_op;
    logic [47:0]             req_a;
    logic [47:0]             req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [47:0]             rsp_result;
    logic [47:0]             rsp_y;
    logic                    rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_y, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_y, rsp_err
    );

endinterface

// File: rtl/mesm6_alu.sv
// Behavioural MESM-6 48-bit ALU: logic ops and end-around-carry add finish in one cycle,
// done is sticky until an ALU_NOP edge, floating-point and shift ops never finish.
module mesm6_alu
    import mesm6_pkg::*;
(
    input  logic                    clk,
    input  logic [47:0]             a,
    input  logic [47:0]             b,
    input  logic [ALU_OP_WIDTH-1:0] op,
    output logic [47:0]             result,
    output logic [47:0]             y,
    output logic                    done
);

    logic [48:0] sum;
    logic [47:0] sum_eac;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign sum_eac = sum[47:0] + {47'd0, sum[48]};

    always_ff @(posedge clk) begin
        if (op == ALU_NOP) begin
            done <= 1'b0;
        end else if (!done) begin
            case (op)
                ALU_AND: begin
                    result <= a & b;
                    y      <= '0;
                    done   <= 1'b1;
                end
                ALU_OR: begin
                    result <= a | b;
                    y      <= '0;
                    done   <= 1'b1;
                end
                ALU_XOR: begin
                    result <= a ^ b;
                    y      <= a;
                    done   <= 1'b1;
                end
                ALU_ADD_CARRY_AROUND: begin
                    result <= sum_eac;
                    y      <= '0;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mesm6_alu_ctl.sv
// Sequencing controller between the instruction decoder and the MESM-6 ALU.
// Optional RUN-state timeout is enabled by defining MESM6_ALU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request, ALU held at NOP
// RUN   | latched op driven onto the ALU, waiting for done (or timeout)
// RESP  | response held until taken, ALU at NOP so its sticky done clears
module mesm6_alu_ctl
    import mesm6_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mesm6_alu_ctl_if.slave          bus,
    output logic                    busy,
    output logic [47:0]             alu_a,
    output logic [47:0]             alu_b,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [47:0]             alu_result,
    input  logic [47:0]             alu_y,
    input  logic                    alu_done
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mesm6_alu_ctl: TIMEOUT must be at least 2");
    end

    alu_ctl_state_t          state;
    logic [ALU_OP_WIDTH-1:0] op_q;
    logic [47:0]             result_q;
    logic [47:0]             y_q;

`ifdef MESM6_ALU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             err_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= ALU_NOP;
            alu_a    <= '0;
            alu_b    <= '0;
            result_q <= '0;
            y_q      <= '0;
`ifdef MESM6_ALU_TIMEOUT_EN
            cnt      <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        alu_a <= bus.req_a;
                        alu_b <= bus.req_b;
`ifdef MESM6_ALU_TIMEOUT_EN
                        cnt   <= '0;
`endif
                        // A NOP request never touches the ALU and answers with zeros.
                        if (bus.req_op == ALU_NOP) begin
                            result_q <= '0;
                            y_q      <= '0;
`ifdef MESM6_ALU_TIMEOUT_EN
                            err_q    <= 1'b0;
`endif
                            state    <= RESP;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    // done takes priority over a timeout landing on the same edge.
                    if (alu_done) begin
                        result_q <= alu_result;
                        y_q      <= alu_y;
`ifdef MESM6_ALU_TIMEOUT_EN
                        err_q    <= 1'b0;
`endif
                        state    <= RESP;
                    end
`ifdef MESM6_ALU_TIMEOUT_EN
                    else if (cnt == CNT_LAST) begin
                        result_q <= '0;
                        y_q      <= '0;
                        err_q    <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_result = result_q;
    assign bus.rsp_y      = y_q;
    assign busy           = (state != IDLE);
    assign alu_op         = (state == RUN) ? op_q : ALU_NOP;

`ifdef MESM6_ALU_TIMEOUT_EN
    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule
